adc_dma_burst_sched: RTL and testbench

Burst scheduler for the ADC DMA write path. Shares the single M00_AXI burst-write master (fixed 8-beat × 32-bit INCR bursts, init/done/error handshake) among NUM_CH ADC sample FIFOs. It uses round-robin arbitration and keeps one ring-buffer write pointer per channel in system memory. It sits between the S00_AXI control registers (enable, base, size) and the master engine's INIT/DONE/ERROR ports.

---
 rtl/adc_dma_burst_sched_pkg.sv | 34 +++
 rtl/adc_dma_burst_sched_if.sv | 28 ++
 rtl/adc_dma_burst_sched_arbiter.sv | 34 +++
 rtl/adc_dma_burst_sched.sv | 175 +++++++++++++++++
 tb/tb_adc_dma_burst_sched.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_dma_burst_sched_pkg.sv
// adc_dma_pkg: shared types and constants for the ADC DMA burst scheduler.
// Holds the FSM state type, burst geometry and the ring pointer wrap rule.
package adc_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int BURST_BYTES    = DEF_BURST_LEN * DEF_DATA_WIDTH / 8;
    localparam int PTR_W          = 64;

    // Advance a ring offset by one burst; restart at 0 if the following
    // burst would run past the end of the ring.
    function automatic logic [PTR_W-1:0] next_ptr(
        input logic [PTR_W-1:0] ptr,
        input logic [PTR_W-1:0] size,
        input logic [PTR_W-1:0] bytes = PTR_W'(BURST_BYTES)
    );
        logic [PTR_W-1:0] nxt;
        nxt = ptr + bytes;
        if (nxt + bytes > size) begin
            return '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/adc_dma_burst_sched_if.sv
// Burst-write master handshake between the scheduler and the AXI engine.
// master = scheduler side, slave = engine side.
interface adc_dma_burst_sched_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_CH-1:0]     grant;
    logic                  txn_init;
    logic [ADDR_WIDTH-1:0] txn_addr;
    logic                  txn_done;
    logic                  txn_error;

    modport master (
        output grant,
        output txn_init,
        output txn_addr,
        input  txn_done,
        input  txn_error
    );

    modport slave (
        input  grant,
        input  txn_init,
        input  txn_addr,
        output txn_done,
        output txn_error
    );
endinterface

// File: rtl/adc_dma_burst_sched_arbiter.sv
// Round-robin channel picker: the requester closest after i_last wins.
// Purely combinational; o_hit is low when nobody requests.
module adc_dma_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CW     = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CW-1:0]     i_last,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CW-1:0]     o_idx,
    output logic              o_hit
);
    int w_dist;
    int w_best;

    // Pick the requester with the smallest distance from i_last+1.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_hit  = |i_req;
        w_best = NUM_CH;
        w_dist = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_dist = (j + NUM_CH - 1 - int'(i_last)) % NUM_CH;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = CW'(j);
            end
        end
        if (o_hit) begin
            o_gnt[o_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/adc_dma_burst_sched.sv
// Burst scheduler sharing one 8-beat AXI write master among ADC FIFOs.
// Keeps a ring write pointer per channel and arbitrates round-robin.
module adc_dma_burst_sched
    import adc_dma_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LEVEL_WIDTH = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         enable,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_base,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_size,
    input  logic [NUM_CH*LEVEL_WIDTH-1:0] ch_level,
    adc_dma_burst_sched_if.master        bus,
    output logic [NUM_CH*ADDR_WIDTH-1:0] ch_wr_ptr,
    output logic [NUM_CH-1:0]            wrap_pulse,
    output logic                         busy,
    output logic                         err_sticky
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BB = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0]  BB_A      = ADDR_WIDTH'(BB);
    localparam logic [LEVEL_WIDTH-1:0] LVL_MIN   = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [CW-1:0]          LAST_INIT = CW'(NUM_CH - 1);

    state_t r_state;
    state_t w_next;
    logic   w_init;
    logic   w_busy;

    logic [NUM_CH-1:0]     w_req;
    logic [NUM_CH-1:0]     w_arb_gnt;
    logic [CW-1:0]         w_arb_idx;
    logic                  w_arb_hit;
    logic [ADDR_WIDTH-1:0] w_base [NUM_CH];
    logic [ADDR_WIDTH-1:0] w_size [NUM_CH];
    logic [ADDR_WIDTH-1:0] w_nxt_ptr;

    logic [CW-1:0]         r_last;
    logic [CW-1:0]         r_cur;
    logic [NUM_CH-1:0]     r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_ptr [NUM_CH];
    logic [NUM_CH-1:0]     r_wrap;
    logic                  r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_base[g] = ch_base[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_size[g] = ch_size[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_req[g]  = (ch_level[g*LEVEL_WIDTH +: LEVEL_WIDTH] >= LVL_MIN)
                         && (w_size[g] >= BB_A);
        assign ch_wr_ptr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_ptr[g];
    end

    adc_dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_arb (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_hit  (w_arb_hit)
    );

    assign w_nxt_ptr = ADDR_WIDTH'(next_ptr(PTR_W'(r_ptr[r_cur]),
                                            PTR_W'(w_size[r_cur]),
                                            PTR_W'(BB)));

    assign bus.grant    = r_grant;
    assign bus.txn_init = w_init;
    assign bus.txn_addr = r_addr;
    assign wrap_pulse   = r_wrap;
    assign busy         = w_busy;
    assign err_sticky   = r_err;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next = r_state;
        w_init = 1'b0;
        w_busy = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (enable) w_next = S_ARB;
            end
            S_ARB: begin
                if (!enable)        w_next = S_IDLE;
                else if (w_arb_hit) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_init = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.txn_done) begin
                    w_next = bus.txn_error ? S_HALT : S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next = enable ? S_ARB : S_IDLE;
            end
            S_HALT: begin
                if (!enable) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the winning channel, its grant and burst address.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_last  <= LAST_INIT;
            r_cur   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
        end else begin
            unique case (r_state)
                S_ARB: begin
                    if (enable && w_arb_hit) begin
                        r_grant <= w_arb_gnt;
                        r_addr  <= w_base[w_arb_idx] + r_ptr[w_arb_idx];
                        r_last  <= w_arb_idx;
                        r_cur   <= w_arb_idx;
                    end
                end
                S_WAIT: begin
                    if (bus.txn_done && bus.txn_error) r_grant <= '0;
                end
                S_UPDATE, S_HALT: r_grant <= '0;
                default: ;
            endcase
        end
    end

    // Ring pointers: cleared on start, advanced after a good burst.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_CH; i++) r_ptr[i] <= '0;
            r_wrap <= '0;
        end else begin
            r_wrap <= '0;
            if (r_state == S_IDLE && enable) begin
                for (int i = 0; i < NUM_CH; i++) r_ptr[i] <= '0;
            end else if (r_state == S_UPDATE) begin
                r_ptr[r_cur] <= w_nxt_ptr;
                if (w_nxt_ptr == '0) r_wrap[r_cur] <= 1'b1;
            end
        end
    end

    // Sticky master error, cleared when a new run starts.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && enable) begin
            r_err <= 1'b0;
        end else if (r_state == S_WAIT && bus.txn_done && bus.txn_error) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_dma_burst_sched.sv
// Testbench for adc_dma_burst_sched with a ring/round-robin reference model.
// Stimulus is driven and outputs sampled on the falling clock edge.
module tb_adc_dma_burst_sched;
    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int LW  = 8;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b1;
    logic enable  = 1'b0;
    logic [NCH*AW-1:0] ch_base;
    logic [NCH*AW-1:0] ch_size;
    logic [NCH*LW-1:0] ch_level;
    logic [NCH*AW-1:0] ch_wr_ptr;
    logic [NCH-1:0]    wrap_pulse;
    logic              busy;
    logic              err_sticky;

    logic [AW-1:0] base [NCH];
    logic [AW-1:0] size [NCH];
    int            lvl  [NCH];

    int total = 0;
    int bad   = 0;

    int            m_last;
    logic [AW-1:0] m_ptr [NCH];

    adc_dma_burst_sched_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW)) bus ();

    adc_dma_burst_sched #(
        .NUM_CH      (NCH),
        .ADDR_WIDTH  (AW),
        .BURST_LEN   (8),
        .DATA_WIDTH  (32),
        .LEVEL_WIDTH (LW)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .enable     (enable),
        .ch_base    (ch_base),
        .ch_size    (ch_size),
        .ch_level   (ch_level),
        .bus        (bus),
        .ch_wr_ptr  (ch_wr_ptr),
        .wrap_pulse (wrap_pulse),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    always #5 ACLK = ~ACLK;

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign ch_base[g*AW +: AW]  = base[g];
        assign ch_size[g*AW +: AW]  = size[g];
        assign ch_level[g*LW +: LW] = LW'(lvl[g]);
    end

    function automatic void m_reset();
        m_last = NCH - 1;
        for (int i = 0; i < NCH; i++) m_ptr[i] = '0;
    endfunction

    // Eligible = at least one burst of data and a ring that holds a burst.
    function automatic int m_pick();
        int c;
        for (int k = 1; k <= NCH; k++) begin
            c = (m_last + k) % NCH;
            if (lvl[c] >= 8 && size[c] >= 32) return c;
        end
        return -1;
    endfunction

    function automatic bit m_advance(input int c);
        longint p;
        p = longint'(m_ptr[c]);
        if (p + 64 > longint'(size[c])) begin
            m_ptr[c] = '0;
            return 1'b1;
        end
        m_ptr[c] = AW'(p + 32);
        return 1'b0;
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        bus.txn_done  = 1'b0;
        bus.txn_error = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        m_reset();
        @(negedge ACLK);
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (bus.txn_init) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic send_done(input bit err, input int lat);
        repeat (lat + 1) @(negedge ACLK);
        bus.txn_done  = 1'b1;
        bus.txn_error = err;
        @(negedge ACLK);
        bus.txn_done  = 1'b0;
        bus.txn_error = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NCH; i++) begin
            base[i] = '0; size[i] = '0; lvl[i] = 0;
        end
        bus.txn_done = 1'b0; bus.txn_error = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        total++;
        if (bus.grant !== '0 || bus.txn_init !== 1'b0) begin
            bad++; $display("FAIL rst_grant_init got=%b/%b want=0/0", bus.grant, bus.txn_init);
        end
        total++;
        if (bus.txn_addr !== '0 || ch_wr_ptr !== '0) begin
            bad++; $display("FAIL rst_addr_ptr got=%h/%h want=0", bus.txn_addr, ch_wr_ptr);
        end
        total++;
        if (busy !== 1'b0 || err_sticky !== 1'b0 || wrap_pulse !== '0) begin
            bad++; $display("FAIL rst_flags got=%b%b%b want=000", busy, err_sticky, wrap_pulse);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        m_reset();
        @(negedge ACLK);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        base[0] = 32'h1000; size[0] = 32'h100; lvl[0] = 8;
        base[1] = 32'h2000; size[1] = 32'h100; lvl[1] = 0;
        enable = 1'b1;
        @(negedge ACLK);
        total++;
        if (busy !== 1'b1 || bus.txn_init !== 1'b0) begin
            bad++; $display("FAIL single_arb busy=%b init=%b want=1/0", busy, bus.txn_init);
        end
        @(negedge ACLK);
        total++;
        if (bus.txn_init !== 1'b1 || bus.txn_addr !== 32'h1000 || bus.grant !== 2'b01) begin
            bad++; $display("FAIL single_issue init=%b addr=%h grant=%b want=1/1000/01",
                            bus.txn_init, bus.txn_addr, bus.grant);
        end
        @(negedge ACLK);
        total++;
        if (bus.txn_init !== 1'b0 || bus.grant !== 2'b01) begin
            bad++; $display("FAIL single_pulse init=%b grant=%b want=0/01", bus.txn_init, bus.grant);
        end
        send_done(1'b0, 0);
        @(negedge ACLK);
        total++;
        if (ch_wr_ptr[AW-1:0] !== 32'h20 || bus.grant !== 2'b00 || wrap_pulse !== 2'b00) begin
            bad++; $display("FAIL single_ptr ptr=%h grant=%b wrap=%b want=20/00/00",
                            ch_wr_ptr[AW-1:0], bus.grant, wrap_pulse);
        end
    endtask

    task automatic test_alternate();
        int c; bit ok; bit ew;
        logic [NCH-1:0] eg, ewp;
        logic [AW-1:0] got [3];
        logic [AW-1:0] want [3];
        want[0] = 32'h1000; want[1] = 32'h2000; want[2] = 32'h1020;
        do_reset();
        base[0] = 32'h1000; size[0] = 32'h100; lvl[0] = 8;
        base[1] = 32'h2000; size[1] = 32'h100; lvl[1] = 8;
        enable = 1'b1;
        for (int n = 0; n < 8; n++) begin
            c = m_pick();
            wait_init(ok);
            total++;
            if (!ok || c < 0) begin
                bad++; $display("FAIL alt_init ok=%0b ch=%0d", ok, c); break;
            end
            eg = NCH'(1) << c;
            if (n < 3) got[n] = bus.txn_addr;
            total++;
            if (bus.txn_addr !== base[c] + m_ptr[c] || bus.grant !== eg) begin
                bad++; $display("FAIL alt_issue addr=%h grant=%b want=%h/%b",
                                bus.txn_addr, bus.grant, base[c] + m_ptr[c], eg);
            end
            m_last = c;
            send_done(1'b0, int'($urandom_range(0, 4)));
            ew = m_advance(c);
            ewp = ew ? (NCH'(1) << c) : '0;
            @(negedge ACLK);
            total++;
            if (ch_wr_ptr[c*AW +: AW] !== m_ptr[c] || wrap_pulse !== ewp) begin
                bad++; $display("FAIL alt_ptr ch=%0d ptr=%h wrap=%b want=%h/%b",
                                c, ch_wr_ptr[c*AW +: AW], wrap_pulse, m_ptr[c], ewp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++; $display("FAIL alt_seq%0d addr=%h want=%h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int c; bit ok; bit ew;
        logic [NCH-1:0] eg, ewp;
        logic [AW-1:0] sz [2];
        sz[0] = 32'h60; sz[1] = 32'h50;
        for (int s = 0; s < 2; s++) begin
            do_reset();
            base[0] = 32'h1000; size[0] = sz[s]; lvl[0] = 8;
            base[1] = 32'h2000; size[1] = 32'h100; lvl[1] = 0;
            enable = 1'b1;
            for (int n = 0; n < 4; n++) begin
                c = m_pick();
                wait_init(ok);
                total++;
                if (!ok || c != 0) begin
                    bad++; $display("FAIL wrap_init ok=%0b ch=%0d", ok, c); break;
                end
                eg = NCH'(1) << c;
                total++;
                if (bus.txn_addr !== base[c] + m_ptr[c] || bus.grant !== eg) begin
                    bad++; $display("FAIL wrap_issue addr=%h grant=%b want=%h/%b",
                                    bus.txn_addr, bus.grant, base[c] + m_ptr[c], eg);
                end
                m_last = c;
                send_done(1'b0, int'($urandom_range(0, 3)));
                ew = m_advance(c);
                ewp = ew ? (NCH'(1) << c) : '0;
                @(negedge ACLK);
                total++;
                if (ch_wr_ptr[c*AW +: AW] !== m_ptr[c] || wrap_pulse !== ewp) begin
                    bad++; $display("FAIL wrap_ptr ptr=%h wrap=%b want=%h/%b",
                                    ch_wr_ptr[c*AW +: AW], wrap_pulse, m_ptr[c], ewp);
                end
            end
        end
    endtask

    task automatic test_random();
        int c; bit ok; bit ew; int k;
        logic [NCH-1:0] eg, ewp;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            base[i] = $urandom;
            size[i] = AW'($urandom_range(32, 512));
            lvl[i]  = int'($urandom_range(0, 12));
        end
        if (m_pick() < 0) lvl[$urandom_range(0, NCH - 1)] = 8;
        enable = 1'b1;
        for (int n = 0; n < 16; n++) begin
            c = m_pick();
            wait_init(ok);
            total++;
            if (!ok || c < 0) begin
                bad++; $display("FAIL rnd_init ok=%0b ch=%0d", ok, c); break;
            end
            eg = NCH'(1) << c;
            total++;
            if (bus.txn_addr !== base[c] + m_ptr[c] || bus.grant !== eg) begin
                bad++; $display("FAIL rnd_issue addr=%h grant=%b want=%h/%b",
                                bus.txn_addr, bus.grant, base[c] + m_ptr[c], eg);
            end
            m_last = c;
            for (int i = 0; i < NCH; i++) lvl[i] = int'($urandom_range(0, 12));
            k = m_pick();
            if (k < 0) lvl[$urandom_range(0, NCH - 1)] = 8;
            send_done(1'b0, int'($urandom_range(0, 5)));
            ew = m_advance(c);
            ewp = ew ? (NCH'(1) << c) : '0;
            @(negedge ACLK);
            total++;
            if (ch_wr_ptr[c*AW +: AW] !== m_ptr[c] || wrap_pulse !== ewp) begin
                bad++; $display("FAIL rnd_ptr ch=%0d ptr=%h wrap=%b want=%h/%b",
                                c, ch_wr_ptr[c*AW +: AW], wrap_pulse, m_ptr[c], ewp);
            end
        end
    endtask

    task automatic test_error();
        bit ok; bit ew; int cnt;
        do_reset();
        base[0] = 32'h1000; size[0] = 32'h100; lvl[0] = 8;
        base[1] = 32'h2000; size[1] = 32'h100; lvl[1] = 0;
        enable = 1'b1;
        wait_init(ok);
        m_last = 0;
        send_done(1'b0, int'($urandom_range(0, 3)));
        ew = m_advance(0);
        wait_init(ok);
        total++;
        if (!ok || bus.txn_addr !== base[0] + m_ptr[0]) begin
            bad++; $display("FAIL err_issue ok=%0b addr=%h want=%h", ok, bus.txn_addr, base[0] + m_ptr[0]);
        end
        send_done(1'b1, int'($urandom_range(0, 3)));
        total++;
        if (err_sticky !== 1'b1 || busy !== 1'b1 || bus.grant !== '0) begin
            bad++; $display("FAIL err_halt err=%b busy=%b grant=%b want=1/1/00",
                            err_sticky, busy, bus.grant);
        end
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            if (bus.txn_init) cnt++;
        end
        total++;
        if (cnt !== 0 || ch_wr_ptr[AW-1:0] !== m_ptr[0]) begin
            bad++; $display("FAIL err_hold inits=%0d ptr=%h want=0/%h", cnt, ch_wr_ptr[AW-1:0], m_ptr[0]);
        end
        enable = 1'b0;
        @(negedge ACLK);
        total++;
        if (busy !== 1'b0 || err_sticky !== 1'b1) begin
            bad++; $display("FAIL err_idle busy=%b err=%b want=0/1", busy, err_sticky);
        end
        enable = 1'b1;
        for (int i = 0; i < NCH; i++) m_ptr[i] = '0;
        @(negedge ACLK);
        total++;
        if (err_sticky !== 1'b0 || ch_wr_ptr !== '0 || busy !== 1'b1) begin
            bad++; $display("FAIL err_restart err=%b ptr=%h busy=%b want=0/0/1",
                            err_sticky, ch_wr_ptr, busy);
        end
    endtask

    task automatic test_enable_drop();
        int c; bit ok; bit ew; int cnt;
        do_reset();
        base[0] = 32'h1000; size[0] = 32'h100; lvl[0] = 8;
        base[1] = 32'h2000; size[1] = 32'h100; lvl[1] = 0;
        enable = 1'b1;
        c = m_pick();
        wait_init(ok);
        enable = 1'b0;
        m_last = c;
        send_done(1'b0, int'($urandom_range(0, 4)));
        ew = m_advance(c);
        @(negedge ACLK);
        total++;
        if (!ok || busy !== 1'b0 || bus.grant !== '0 || ch_wr_ptr[AW-1:0] !== m_ptr[0]) begin
            bad++; $display("FAIL drop_idle ok=%0b busy=%b grant=%b ptr=%h want=1/0/00/%h",
                            ok, busy, bus.grant, ch_wr_ptr[AW-1:0], m_ptr[0]);
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (bus.txn_init) cnt++;
        end
        total++;
        if (cnt !== 0) begin
            bad++; $display("FAIL drop_quiet inits=%0d want=0", cnt);
        end
        lvl[1] = 8;
        enable = 1'b1;
        for (int i = 0; i < NCH; i++) m_ptr[i] = '0;
        c = m_pick();
        wait_init(ok);
        total++;
        if (!ok || c != 1 || bus.grant !== 2'b10 || bus.txn_addr !== 32'h2000) begin
            bad++; $display("FAIL rstw_issue ok=%0b grant=%b addr=%h want=1/10/2000",
                            ok, bus.grant, bus.txn_addr);
        end
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        total++;
        if (bus.grant !== '0 || bus.txn_addr !== '0 || busy !== 1'b0 || ch_wr_ptr !== '0) begin
            bad++; $display("FAIL rstw_clear grant=%b addr=%h busy=%b ptr=%h want=0",
                            bus.grant, bus.txn_addr, busy, ch_wr_ptr);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        m_reset();
        c = m_pick();
        wait_init(ok);
        total++;
        if (!ok || c != 0 || bus.grant !== 2'b01 || bus.txn_addr !== 32'h1000) begin
            bad++; $display("FAIL rstw_resume ok=%0b grant=%b addr=%h want=1/01/1000",
                            ok, bus.grant, bus.txn_addr);
        end
    endtask

    task automatic test_no_elig();
        bit ok; bit ew; int cnt;
        do_reset();
        base[0] = 32'h1000; size[0] = 32'h100; lvl[0] = 7;
        base[1] = 32'h2000; size[1] = 32'h100; lvl[1] = 7;
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (bus.txn_init) cnt++;
            bus.txn_done  = 1'($urandom_range(0, 1));
            bus.txn_error = 1'($urandom_range(0, 1));
        end
        bus.txn_done = 1'b0; bus.txn_error = 1'b0;
        @(negedge ACLK);
        total++;
        if (cnt !== 0 || busy !== 1'b1 || err_sticky !== 1'b0 || ch_wr_ptr !== '0) begin
            bad++; $display("FAIL lvl7_idle inits=%0d busy=%b err=%b ptr=%h want=0/1/0/0",
                            cnt, busy, err_sticky, ch_wr_ptr);
        end
        lvl[0] = 8;
        wait_init(ok);
        total++;
        if (!ok || bus.grant !== 2'b01 || bus.txn_addr !== 32'h1000) begin
            bad++; $display("FAIL lvl8_issue ok=%0b grant=%b addr=%h want=1/01/1000",
                            ok, bus.grant, bus.txn_addr);
        end
        m_last = 0;
        send_done(1'b0, 1);
        ew = m_advance(0);
        @(negedge ACLK);
        total++;
        if (ch_wr_ptr[AW-1:0] !== m_ptr[0] || ch_wr_ptr[2*AW-1:AW] !== '0) begin
            bad++; $display("FAIL lvl8_ptr ptr=%h want=%h", ch_wr_ptr, {32'h0, m_ptr[0]});
        end
        do_reset();
        size[0] = 32'h10; lvl[0] = 8; lvl[1] = 0;
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (bus.txn_init) cnt++;
        end
        total++;
        if (cnt !== 0 || busy !== 1'b1) begin
            bad++; $display("FAIL small_ring inits=%0d busy=%b want=0/1", cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_wrap();
        test_random();
        test_error();
        test_enable_drop();
        test_no_elig();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
